a2bus_slave: RTL and testbench

Apple II slot bus front-end for the iCE40 serial card. It synchronizes the asynchronous slot strobes (`_devsel`, `_iosel`, `_iostrobe`) into the `clk_16m` domain and turns each bus cycle into single-clock register or ROM transactions for the card core. It also owns the read-data output enable and the $C800 expansion-ROM ownership flag. It sits between the top-level data-pin `SB_IO` (`D_IN_0`/`D_OUT_0`/`OUTPUT_ENABLE`) and the serial core.

---
 rtl/a2bus_pkg.sv | 26 ++
 rtl/a2_sync.sv | 35 +++
 rtl/a2bus_slave.sv | 193 +++++++++++++++++++
 tb/tb_a2bus_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/a2bus_pkg.sv
// a2bus_pkg: shared types and constants for the Apple II slot bus front-end
package a2bus_pkg;

    // Bus-cycle FSM states
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DRIVE,
        WR_TRACK,
        IGNORE
    } state_t;

    // Which slot select started the current access
    typedef enum logic [1:0] {
        DEV,
        IO,
        STROBE
    } kind_t;

    // A10..A0 of $CFFF: an iostrobe access here releases the expansion ROM space
    localparam logic [10:0] CFFF_ADDR = 11'h7FF;

    // Device register index width (A3..A0)
    localparam int REG_AW = 4;

endpackage

// File: rtl/a2_sync.sv
// a2_sync: multi-stage synchronizer for a bundle of asynchronous bus signals
//
// Ports:
//   clk    in  1        sampling clock
//   rst_n  in  1        asynchronous active-low reset, loads RST_VAL into every stage
//   d      in  W        asynchronous inputs
//   q      out W        synchronized outputs, delayed by STAGES clocks
//
// Every bit shares one pipeline so a bundle (strobes, rw, address, data)
// stays cycle-aligned at the output.
module a2_sync #(
    parameter int           W       = 1,
    parameter int           STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/a2bus_slave.sv
// a2bus_slave: Apple II slot bus front-end turning bus cycles into register/ROM transactions
//
// Ports:
//   clk_16m     in  1   16 MHz system clock
//   _reset      in  1   Apple II reset, asynchronous active-low
//   addr_in     in  12  slot address A11..A0
//   data_in     in  8   bus data from the pads
//   rw          in  1   1 = read, 0 = write
//   _devsel     in  1   device select, active-low, asynchronous
//   _iosel      in  1   slot ROM select ($Cnxx), active-low, asynchronous
//   _iostrobe   in  1   expansion ROM select ($C800-$CFFF), active-low, asynchronous
//   data_out    out 8   read data to the pads
//   data_oe     out 1   pad output enable
//   reg_addr    out 4   device register index (A3..A0)
//   reg_wdata   out 8   register write data
//   reg_wr      out 1   single-cycle register write strobe
//   reg_rd      out 1   single-cycle register read strobe
//   reg_rdata   in  8   register read data, valid 1 clock after reg_rd
//   rom_addr    out 11  ROM address
//   rom_rd      out 1   single-cycle ROM read strobe
//   rom_rdata   in  8   ROM data, valid 1 clock after rom_rd
//   exp_en      out 1   card owns the $C800-$CFFF space
module a2bus_slave
    import a2bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_16m,
    input  logic        _reset,
    input  logic [11:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        rw,
    input  logic        _devsel,
    input  logic        _iosel,
    input  logic        _iostrobe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic [10:0] rom_addr,
    output logic        rom_rd,
    input  logic [7:0]  rom_rdata,
    output logic        exp_en
);

    // Selects are packed {devsel, iosel, iostrobe}, all active-low
    logic [23:0] synced;
    logic [2:0]  sel_s;
    logic        rw_s;
    logic [11:0] addr_s;
    logic [7:0]  data_s;

    a2_sync #(
        .W       (24),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('1)
    ) u_sync (
        .clk   (clk_16m),
        .rst_n (_reset),
        .d     ({_devsel, _iosel, _iostrobe, rw, addr_in, data_in}),
        .q     (synced)
    );

    assign {sel_s, rw_s, addr_s, data_s} = synced;

    // A11 is not needed: register, slot ROM and expansion ROM decoding use A10..A0
    logic unused_a11;
    assign unused_a11 = addr_s[11];

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [2:0]       sel_prev_q;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic             reg_wr_q, reg_wr_d;
    logic             reg_rd_q, reg_rd_d;
    logic [10:0]      rom_addr_q, rom_addr_d;
    logic             rom_rd_q, rom_rd_d;
    logic             exp_en_q, exp_en_d;

    logic [2:0] fall;
    logic       start;
    kind_t      start_kind;
    logic       cfff;
    logic       ignore_start;
    logic       sel_released;

    assign fall         = sel_prev_q & ~sel_s;
    assign start        = |fall;
    assign start_kind   = fall[2] ? DEV : fall[1] ? IO : STROBE;
    assign cfff         = addr_s[10:0] == CFFF_ADDR;
    // Expansion ROM accesses are only served while owned; $CFFF gives ownership up
    assign ignore_start = start_kind == STROBE && (!exp_en_q || cfff);
    // End of access: the select that started it has returned high
    assign sel_released = kind_q == DEV ? sel_s[2] : kind_q == IO ? sel_s[1] : sel_s[0];

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        data_out_d  = data_out_q;
        data_oe_d   = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_rd_d    = 1'b0;
        exp_en_d    = exp_en_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    kind_d  = start_kind;
                    state_d = ignore_start ? IGNORE : rw_s ? RD_REQ : WR_TRACK;
                    if (start_kind == DEV) reg_addr_d = addr_s[REG_AW-1:0];
                    else if (!ignore_start) rom_addr_d = start_kind == IO ? {3'b111, addr_s[7:0]} : addr_s[10:0];
                    if (start_kind == IO) exp_en_d = 1'b1;
                    if (start_kind == STROBE && cfff) exp_en_d = 1'b0;
                    reg_rd_d = !ignore_start && rw_s && start_kind == DEV;
                    rom_rd_d = !ignore_start && rw_s && start_kind != DEV;
                    if (!ignore_start && !rw_s) reg_wdata_d = data_s;
                end
            end
            RD_REQ: state_d = RD_DRIVE;
            RD_DRIVE: begin
                // Read data is captured on the first RD_DRIVE clock, one full clock
                // after the strobe, and then held for the rest of the access
                if (sel_released) begin
                    state_d = IDLE;
                end else begin
                    data_oe_d = 1'b1;
                    if (!data_oe_q) data_out_d = kind_q == DEV ? reg_rdata : rom_rdata;
                end
            end
            WR_TRACK: begin
                // Data follows the bus until the select rises, so the last low sample wins
                if (sel_released) begin
                    state_d  = IDLE;
                    reg_wr_d = kind_q == DEV;
                end else begin
                    reg_wdata_d = data_s;
                end
            end
            IGNORE: if (sel_released) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_16m or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            kind_q      <= DEV;
            sel_prev_q  <= 3'b111;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            exp_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            sel_prev_q  <= sel_s;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            rom_addr_q  <= rom_addr_d;
            rom_rd_q    <= rom_rd_d;
            exp_en_q    <= exp_en_d;
        end
    end

    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign rom_addr  = rom_addr_q;
    assign rom_rd    = rom_rd_q;
    assign exp_en    = exp_en_q;

endmodule

// File: tb/tb_a2bus_slave.sv
// tb_a2bus_slave: directed self-checking bench for the slot bus front-end
module tb_a2bus_slave;

    logic        clk_16m = 1'b0;
    logic        _reset  = 1'b0;
    logic [11:0] addr_in = '0;
    logic [7:0]  data_in = '0;
    logic        rw      = 1'b1;
    logic        _devsel = 1'b1;
    logic        _iosel  = 1'b1;
    logic        _iostrobe = 1'b1;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata = 8'hA7;
    logic [10:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_rdata = 8'h5E;
    logic        exp_en;

    a2bus_slave #(.SYNC_STAGES(2)) dut (
        .clk_16m   (clk_16m),
        ._reset    (_reset),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .rw        (rw),
        ._devsel   (_devsel),
        ._iosel    (_iosel),
        ._iostrobe (_iostrobe),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_rdata (rom_rdata),
        .exp_en    (exp_en)
    );

    always #31 clk_16m = ~clk_16m;

    int errors = 0;
    int checks = 0;

    // Strobe monitor, sampled on the falling edge away from state changes
    int          n_reg_rd = 0, n_reg_wr = 0, n_rom_rd = 0, n_oe = 0;
    logic [7:0]  last_wdata = '0;
    logic [3:0]  last_wr_addr = '0;
    logic [3:0]  last_rd_addr = '0;
    logic [10:0] last_rom_addr = '0;

    always @(negedge clk_16m) begin
        if (reg_rd) begin n_reg_rd++; last_rd_addr = reg_addr; end
        if (reg_wr) begin n_reg_wr++; last_wdata = reg_wdata; last_wr_addr = reg_addr; end
        if (rom_rd) begin n_rom_rd++; last_rom_addr = rom_addr; end
        if (data_oe) n_oe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus access: selects (active-low {dev,io,strobe}) held low for 8 clocks.
    // Reports the clock count until data_oe rose (0 = never) and bus state at the end.
    task automatic access(input logic [2:0] sel_n, input logic [11:0] a, input logic r,
                          input logic [7:0] d, output int oe_lat, output logic [7:0] dout_first,
                          output logic oe_end, output logic [7:0] dout_end);
        addr_in = a;
        rw      = r;
        data_in = d;
        {_devsel, _iosel, _iostrobe} = sel_n;
        oe_lat = 0;
        dout_first = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_16m);
            #1;
            if (data_oe && oe_lat == 0) begin
                oe_lat = i;
                dout_first = data_out;
            end
        end
        oe_end = data_oe;
        dout_end = data_out;
        #4;
        {_devsel, _iosel, _iostrobe} = 3'b111;
        #1 data_in = 8'hFF;
        repeat (5) @(posedge clk_16m);
        #5;
    endtask

    int          lat;
    logic [7:0]  d_first, d_end;
    logic        oe_end;
    int          b_rd, b_wr, b_rom, b_oe;

    initial begin
        // Reset state
        #100;
        chk("rst_data_oe", data_oe, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_strobes", {reg_wr, reg_rd, rom_rd}, 0);
        chk("rst_exp_en", exp_en, 0);
        @(negedge clk_16m);
        _reset = 1'b1;
        repeat (3) @(posedge clk_16m);
        #5;

        // Devsel read of register 5
        b_rd = n_reg_rd; b_rom = n_rom_rd;
        access(3'b011, 12'h0F5, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("dev_rd_pulses", n_reg_rd - b_rd, 1);
        chk("dev_rd_addr", last_rd_addr, 4'h5);
        chk("dev_rd_no_rom", n_rom_rd - b_rom, 0);
        chk("dev_rd_oe_within_5", (lat >= 1 && lat <= 5), 1);
        chk("dev_rd_data_first", d_first, 8'hA7);
        chk("dev_rd_oe_held", oe_end, 1);
        chk("dev_rd_data_held", d_end, 8'hA7);
        chk("dev_rd_oe_dropped", data_oe, 0);

        // Devsel write of 3C to register 8, data goes to FF just after select rises
        b_wr = n_reg_wr; b_oe = n_oe;
        access(3'b011, 12'h0F8, 1'b0, 8'h3C, lat, d_first, oe_end, d_end);
        chk("dev_wr_pulses", n_reg_wr - b_wr, 1);
        chk("dev_wr_data", last_wdata, 8'h3C);
        chk("dev_wr_addr", last_wr_addr, 4'h8);
        chk("dev_wr_no_oe", n_oe - b_oe, 0);

        // Iostrobe read of $C900 while not owning the expansion space
        b_rom = n_rom_rd; b_oe = n_oe;
        access(3'b110, 12'h900, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("strobe_off_no_rom", n_rom_rd - b_rom, 0);
        chk("strobe_off_no_oe", n_oe - b_oe, 0);
        chk("strobe_off_exp_en", exp_en, 0);

        // Iosel read of $C210 claims the expansion space
        b_rom = n_rom_rd;
        access(3'b101, 12'h210, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("iosel_exp_en", exp_en, 1);
        chk("iosel_rom_pulses", n_rom_rd - b_rom, 1);
        chk("iosel_rom_addr", last_rom_addr, 11'h710);
        chk("iosel_data", d_first, 8'h5E);

        // $C900 again, now served from ROM
        b_rom = n_rom_rd;
        rom_rdata = 8'h91;
        access(3'b110, 12'h900, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("strobe_on_rom_pulses", n_rom_rd - b_rom, 1);
        chk("strobe_on_rom_addr", last_rom_addr, 11'h100);
        chk("strobe_on_data", d_first, 8'h91);

        // $CFFF releases the expansion space and drives nothing
        b_rom = n_rom_rd; b_oe = n_oe;
        access(3'b110, 12'hFFF, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("cfff_exp_en", exp_en, 0);
        chk("cfff_no_rom", n_rom_rd - b_rom, 0);
        chk("cfff_no_oe", n_oe - b_oe, 0);

        // Devsel and iosel together: devsel wins, exp_en untouched
        b_rd = n_reg_rd; b_rom = n_rom_rd;
        reg_rdata = 8'h4B;
        access(3'b001, 12'h0F2, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("prio_reg_rd", n_reg_rd - b_rd, 1);
        chk("prio_no_rom", n_rom_rd - b_rom, 0);
        chk("prio_exp_en", exp_en, 0);
        chk("prio_data", d_first, 8'h4B);

        // Iosel write also claims the space, with no register strobe
        b_wr = n_reg_wr;
        access(3'b101, 12'h233, 1'b0, 8'h12, lat, d_first, oe_end, d_end);
        chk("iosel_wr_exp_en", exp_en, 1);
        chk("iosel_wr_no_reg_wr", n_reg_wr - b_wr, 0);

        // Reset asserted while driving read data
        addr_in = 12'h0F1;
        rw = 1'b1;
        _devsel = 1'b0;
        repeat (6) @(posedge clk_16m);
        #5;
        chk("mid_rd_oe_before_reset", data_oe, 1);
        #10 _reset = 1'b0;
        #1;
        chk("async_rst_oe", data_oe, 0);
        chk("async_rst_exp_en", exp_en, 0);
        chk("async_rst_data_out", data_out, 0);
        _devsel = 1'b1;
        #20 _reset = 1'b1;
        repeat (4) @(posedge clk_16m);
        #5;

        // Normal read after reset release
        b_rd = n_reg_rd;
        reg_rdata = 8'hC4;
        access(3'b011, 12'h0F3, 1'b1, 8'h00, lat, d_first, oe_end, d_end);
        chk("post_rst_reg_rd", n_reg_rd - b_rd, 1);
        chk("post_rst_addr", last_rd_addr, 4'h3);
        chk("post_rst_data", d_first, 8'hC4);
        chk("post_rst_oe_within_5", (lat >= 1 && lat <= 5), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
